// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor (a - b), LSB first, start/ready/done handshake
// Optional signed-overflow output enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             br_next;
  logic             last_bit;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Operand sign bits are kept separately because the shift registers lose them.
  logic a_msb;
  logic b_msb;
`endif

  // One full-subtractor slice operating on the current LSBs.
  assign d_bit    = a_sh[0] ^ b_sh[0] ^ br;
  assign br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign last_bit = (cnt == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs decoded purely from the state register.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accepted start, shift one slice per RUN cycle, publish on the last slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {d_bit, res_sh[WIDTH-1:1]};
          br     <= br_next;
          if (last_bit) begin
            // Counter holds at WIDTH-1; it is cleared again on the next capture.
            diff       <= {d_bit, res_sh[WIDTH-1:1]};
            borrow_out <= br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            overflow   <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .overflow   (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run one subtraction from IDLE and check latency, results and the single done pulse.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] ed,
                        input logic eb, input logic eo, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    a     = va;
    b     = vb;
    @(negedge clk);
    start = 1'b0;
    a     = ~va;
    b     = ~vb;
    check({tag, " busy_after_accept"}, busy, 1);
    lat  = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    if (!seen) begin
      check({tag, " done_timeout"}, 0, 1);
    end else begin
      check({tag, " latency"}, lat, WIDTH + 1);
      check({tag, " diff"}, diff, ed);
      check({tag, " borrow"}, borrow_out, eb);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check({tag, " overflow"}, overflow, eo);
`endif
      @(negedge clk);
      check({tag, " done_one_cycle"}, done, 0);
      check({tag, " ready_after_done"}, ready, 1);
      check({tag, " diff_held"}, diff, ed);
    end
  endtask

  initial begin
    int done_idx[$];
    int done_cnt;
    logic [39:0] rdy_log;
    logic [39:0] done_log;

    vecs[0] = '{8'd200, 8'd55,  8'd145, 1'b0, 1'b0};
    vecs[1] = '{8'd5,   8'd10,  8'hFB,  1'b1, 1'b0};
    vecs[2] = '{8'd0,   8'd0,   8'd0,   1'b0, 1'b0};
    vecs[3] = '{8'd0,   8'd255, 8'd1,   1'b1, 1'b0};
    vecs[4] = '{8'd255, 8'd0,   8'd255, 1'b0, 1'b0};
    vecs[5] = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
    vecs[6] = '{8'h10,  8'h01,  8'h0F,  1'b0, 1'b0};
    vecs[7] = '{8'd1,   8'd2,   8'hFF,  1'b1, 1'b0};
    vecs[8] = '{8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1};
    vecs[9] = '{8'hA5,  8'hA5,  8'h00,  1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset ready", ready, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset diff", diff, 0);
    check("reset borrow", borrow_out, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // Start pulsed with new operands mid-run must not disturb the active operation.
    @(negedge clk);
    start = 1'b1; a = 8'd100; b = 8'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'd1; b = 8'd1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        done_cnt++;
        check("ignore_start diff", diff, 8'd99);
      end
      @(negedge clk);
    end
    check("ignore_start done_count", done_cnt, 1);

    // Start held high: one acceptance every WIDTH+2 cycles.
    start = 1'b1; a = 8'd50; b = 8'd20;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rdy_log[i]  = ready;
      done_log[i] = done;
      if (done) done_idx.push_back(i);
    end
    start = 1'b0;
    check("b2b done_count", done_idx.size(), 4);
    for (int k = 1; k < done_idx.size(); k++) begin
      check("b2b period", done_idx[k] - done_idx[k-1], WIDTH + 2);
    end
    if (done_idx.size() > 0 && done_idx[0] + 2 < 40) begin
      check("b2b ready_after_done", rdy_log[done_idx[0] + 1], 1);
      check("b2b ready_low_after_accept", rdy_log[done_idx[0] + 2], 0);
    end
    check("b2b ready_count", $countones(rdy_log), 4);
    check("b2b diff", diff, 8'd30);
    repeat (WIDTH + 3) @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    start = 1'b1; a = 8'd77; b = 8'd33;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset ready", ready, 1);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset diff", diff, 0);
    check("midreset borrow", borrow_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midreset no_done", done_cnt, 0);
    run_op(8'd77, 8'd33, 8'd44, 1'b0, 1'b0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
